keypad_scanner: RTL



---
 rtl/keypad_scanner_pkg.sv | 19 +
 rtl/keypad_debounce.sv | 60 ++++++
 rtl/keypad_scanner.sv | 126 ++++++++++++
 3 files changed

// File: rtl/keypad_scanner_pkg.sv
// Shared constants, types and helpers for the 4x4 keypad scanner.
// Key codes are {row[1:0], col[1:0]}; the same index addresses the 16-bit scan snapshot.
package keypad_scanner_pkg;

  localparam logic [3:0]  COL_INIT  = 4'b1110;
  localparam logic [3:0]  KEY_CLEAR = 4'hC;
  localparam int unsigned DB_CNT_W  = 3;

  // "none" is always encoded as vld=0 with code=0 so whole-struct compares are exact.
  typedef struct packed {
    logic       vld;
    logic [3:0] code;
  } key_t;

  function automatic logic [3:0] key_code_f(input logic [1:0] row, input logic [1:0] col);
    return {row, col};
  endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Frame-level debouncer: accepts a candidate key after DEBOUNCE_SCANS identical frames.
// Press/release strobes mark the clock edge at which the stable state changes.
module keypad_debounce
  import keypad_scanner_pkg::*;
#(
  parameter int unsigned DEBOUNCE_SCANS = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_frame_end,
  input  key_t i_cand,
  output key_t o_stable,
  output logic o_press,
  output logic o_release
);

  localparam logic [DB_CNT_W-1:0] Thresh = DB_CNT_W'(DEBOUNCE_SCANS);

  key_t                r_pend;
  key_t                r_stable;
  logic [DB_CNT_W-1:0] r_cnt;
  key_t                w_pend_d;
  key_t                w_stable_d;
  logic [DB_CNT_W-1:0] w_cnt_d;

  always_comb begin
    w_pend_d   = r_pend;
    w_cnt_d    = r_cnt;
    w_stable_d = r_stable;
    if (i_frame_end) begin
      if (i_cand == r_pend) begin
        w_cnt_d = (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;
      end else begin
        w_pend_d = i_cand;
        w_cnt_d  = DB_CNT_W'(1);
      end
      if ((w_cnt_d >= Thresh) && (w_pend_d != r_stable)) begin
        w_stable_d = w_pend_d;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pend   <= '0;
      r_cnt    <= '0;
      r_stable <= '0;
    end else begin
      r_pend   <= w_pend_d;
      r_cnt    <= w_cnt_d;
      r_stable <= w_stable_d;
    end
  end

  assign o_stable = r_stable;
  // A direct k->j change counts as a press; only a change to "none" is a release.
  assign o_press   = w_stable_d.vld && (w_stable_d != r_stable);
  assign o_release = !w_stable_d.vld && r_stable.vld;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column strobing, frame snapshot, single-key candidate encoding,
// debounced press pulses and a 4-digit BCD entry shift register.
module keypad_scanner
  import keypad_scanner_pkg::*;
#(
  parameter int unsigned SCAN_DIV       = 131072,
  parameter int unsigned DEBOUNCE_SCANS = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [3:0]  i_row_n,
  output logic [3:0]  o_col_n,
  output logic [3:0]  o_key_code,
  output logic        o_key_valid,
  output logic        o_key_held,
  output logic [15:0] o_digits
);

  localparam int unsigned       DwellW    = $clog2(SCAN_DIV);
  localparam logic [DwellW-1:0] DwellLast = DwellW'(SCAN_DIV - 1);

  logic [DwellW-1:0] r_dwell;
  logic [3:0]        r_col_n;
  logic [1:0]        r_col_idx;
  logic [15:0]       r_snap;
  logic [3:0]        r_key_code;
  logic              r_key_valid;
  logic              r_key_held;
  logic [15:0]       r_digits;

  logic        w_sample;
  logic        w_frame_end;
  logic [15:0] w_snap_next;
  logic [4:0]  w_hits;
  logic [3:0]  w_idx;
  key_t        w_cand;
  key_t        w_stable;
  logic        w_press;
  logic        w_release;
  logic        w_unused_stable;

  assign w_sample    = (r_dwell == DwellLast);
  assign w_frame_end = w_sample && (r_col_idx == 2'd3);

  // Snapshot including the column being sampled this cycle, so frame end sees all 16 keys.
  always_comb begin
    w_snap_next = r_snap;
    for (int r = 0; r < 4; r++) begin
      w_snap_next[key_code_f(2'(r), r_col_idx)] = ~i_row_n[r];
    end
  end

  // Exactly one key down yields its code; zero or several (ghosting) yield "none".
  always_comb begin
    w_hits = '0;
    w_idx  = '0;
    for (int i = 0; i < 16; i++) begin
      if (w_snap_next[i]) begin
        w_hits = w_hits + 5'd1;
        w_idx  = 4'(i);
      end
    end
    w_cand.vld  = (w_hits == 5'd1);
    w_cand.code = w_cand.vld ? w_idx : 4'h0;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_dwell   <= '0;
      r_col_n   <= COL_INIT;
      r_col_idx <= 2'd0;
      r_snap    <= '0;
    end else if (w_sample) begin
      r_dwell   <= '0;
      r_snap    <= w_snap_next;
      r_col_n   <= {r_col_n[2:0], r_col_n[3]};
      r_col_idx <= r_col_idx + 2'd1;
    end else begin
      r_dwell <= r_dwell + 1'b1;
    end
  end

  keypad_debounce #(
    .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
  ) u_debounce (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_frame_end (w_frame_end),
    .i_cand      (w_cand),
    .o_stable    (w_stable),
    .o_press     (w_press),
    .o_release   (w_release)
  );

  // Outputs are registered on the same edge the debouncer commits its new stable state.
  assign w_unused_stable = ^w_stable;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_key_code  <= 4'h0;
      r_key_valid <= 1'b0;
      r_key_held  <= 1'b0;
      r_digits    <= 16'h0000;
    end else begin
      r_key_valid <= w_press;
      if (w_press) begin
        r_key_code <= w_cand.code;
        r_key_held <= 1'b1;
        if (w_cand.code <= 4'd9) begin
          r_digits <= {r_digits[11:0], w_cand.code};
        end else if (w_cand.code == KEY_CLEAR) begin
          r_digits <= 16'h0000;
        end
      end else if (w_release) begin
        r_key_held <= 1'b0;
      end
    end
  end

  assign o_col_n     = r_col_n;
  assign o_key_code  = r_key_code;
  assign o_key_valid = r_key_valid;
  assign o_key_held  = r_key_held;
  assign o_digits    = r_digits;

endmodule
